// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout video blocks.
// Contents: screen geometry, colour constants and the paddle renderer
// state encoding. No ports; imported with `import breakout_pkg::*;`.
package breakout_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } paddle_draw_state_t;

endpackage

// File: rtl/paddle_draw_if.sv
// Bundle between the paddle renderer, its requester and the VGA plot port.
// Signals:
//   go, paddle_x                  : redraw request and paddle centre column
//   vga_x, vga_y, colour, plot    : pixel write towards the VGA adapter
//   busy, done                    : renderer status
// Modports: slave = the renderer, master = the requester/observer side.
interface paddle_draw_if;
    logic       go;
    logic [7:0] paddle_x;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport slave (
        input  go, paddle_x,
        output vga_x, vga_y, colour, plot, busy, done
    );

    modport master (
        output go, paddle_x,
        input  vga_x, vga_y, colour, plot, busy, done
    );
endinterface

// File: rtl/rect_scanner.sv
// Walks a COLS x ROWS rectangle one pixel per cycle, column fastest.
// Ports:
//   clk, resetn      : clock, synchronous active-low reset
//   start            : begin a new rectangle; offset 0 is current next cycle
//   clear            : abandon any scan and park the counters at zero
//   col_off, row_off : offsets of the pixel that will be current next cycle
//   last             : the current pixel is the final one of the rectangle
// The offsets are presented one cycle early so the owner can register its
// pixel outputs and still have them line up with the scan.
module rect_scanner
    import breakout_pkg::*;
#(
    parameter int COLS = 17,
    parameter int ROWS = 2,
    parameter int CW   = 5,
    parameter int RW   = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          clear,
    output logic [CW-1:0] col_off,
    output logic [RW-1:0] row_off,
    output logic          last
);

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    logic [CW-1:0] col_r, col_n;
    logic [RW-1:0] row_r, row_n;
    logic          active_r, active_n;

    // Final-pixel flag and next counter values (clear beats start beats advance).
    always_comb begin
        col_n    = col_r;
        row_n    = row_r;
        active_n = active_r;
        last     = active_r && (col_r == COL_LAST) && (row_r == ROW_LAST);
        if (clear) begin
            col_n    = {CW{1'b0}};
            row_n    = {RW{1'b0}};
            active_n = 1'b0;
        end else if (start) begin
            col_n    = {CW{1'b0}};
            row_n    = {RW{1'b0}};
            active_n = 1'b1;
        end else if (active_r) begin
            if (last) begin
                col_n    = {CW{1'b0}};
                row_n    = {RW{1'b0}};
                active_n = 1'b0;
            end else if (col_r == COL_LAST) begin
                col_n = {CW{1'b0}};
                row_n = row_r + RW'(1);
            end else begin
                col_n = col_r + CW'(1);
            end
        end else begin
            col_n    = col_r;
            row_n    = row_r;
            active_n = active_r;
        end
    end

    assign col_off = col_n;
    assign row_off = row_n;

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_r    <= {CW{1'b0}};
            row_r    <= {RW{1'b0}};
            active_r <= 1'b0;
        end else begin
            col_r    <= col_n;
            row_r    <= row_n;
            active_r <= active_n;
        end
    end

endmodule

// File: rtl/paddle_draw.sv
// Paddle renderer: on each accepted go, erases the paddle at its previously
// drawn column and draws it at the newly latched column, one pixel per cycle.
// Ports:
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : paddle_draw_if.slave (go/paddle_x in; vga_x/vga_y/colour/plot,
//            busy/done out, all registered)
// The state register and scanner counters describe the pixel on the outputs
// in the current cycle; the output registers are loaded from the next-state
// view so that the first pixel appears the cycle after go is accepted.
module paddle_draw
    import breakout_pkg::*;
#(
    parameter int         HALF_W        = 8,
    parameter int         PADDLE_H      = 2,
    parameter int         PADDLE_Y      = 112,
    parameter logic [2:0] PADDLE_COLOUR = 3'b111
) (
    input  logic          clk,
    input  logic          resetn,
    paddle_draw_if.slave  bus
);

    localparam int COLS = 2 * HALF_W + 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (PADDLE_H > 1) ? $clog2(PADDLE_H) : 1;

    paddle_draw_state_t state_r, state_n;
    logic [7:0]    new_x_r, new_x_n;
    logic [7:0]    old_x_r, old_x_n;
    logic          drawn_r, drawn_n;

    logic          scanning_s;
    logic          start_s;
    logic          clear_s;
    logic [CW-1:0] col_off_s;
    logic [RW-1:0] row_off_s;
    logic          last_s;
    logic [7:0]    centre_s;
    logic [9:0]    column_s;
    logic          on_screen_s;
    logic [2:0]    pix_colour_s;

    rect_scanner #(
        .COLS (COLS),
        .ROWS (PADDLE_H),
        .CW   (CW),
        .RW   (RW)
    ) u_scanner (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start_s),
        .clear   (clear_s),
        .col_off (col_off_s),
        .row_off (row_off_s),
        .last    (last_s)
    );

    // Next-state logic, position latching and completion bookkeeping.
    always_comb begin
        state_n = state_r;
        new_x_n = new_x_r;
        old_x_n = old_x_r;
        drawn_n = drawn_r;
        case (state_r)
            IDLE: begin
                if (bus.go) begin
                    new_x_n = bus.paddle_x;
                    if (drawn_r && (bus.paddle_x == old_x_r)) begin
                        state_n = DONE;
                    end else if (drawn_r) begin
                        state_n = ERASE;
                    end else begin
                        state_n = DRAW;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            ERASE: begin
                if (last_s) begin
                    state_n = DRAW;
                end else begin
                    state_n = ERASE;
                end
            end
            DRAW: begin
                if (last_s) begin
                    state_n = DONE;
                    old_x_n = new_x_r;
                    drawn_n = 1'b1;
                end else begin
                    state_n = DRAW;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Scanner control: restart on entry to a rectangle phase, park otherwise.
    always_comb begin
        scanning_s = (state_n == ERASE) || (state_n == DRAW);
        start_s    = scanning_s && (state_n != state_r);
        clear_s    = !scanning_s;
    end

    // Pixel for the next cycle. Two spare high bits keep columns past 255
    // from wrapping, so bit 9 alone flags a column left of the screen.
    always_comb begin
        if (state_n == ERASE) begin
            centre_s     = old_x_r;
            pix_colour_s = COL_BLACK;
        end else begin
            centre_s     = new_x_n;
            pix_colour_s = PADDLE_COLOUR;
        end
        column_s    = {2'b00, centre_s} - 10'(HALF_W) + 10'(col_off_s);
        on_screen_s = !column_s[9] && (column_s < 10'(SCREEN_W));
    end

    // State, position and registered output updates.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= IDLE;
            new_x_r    <= 8'd0;
            old_x_r    <= 8'd0;
            drawn_r    <= 1'b0;
            bus.vga_x  <= 8'd0;
            bus.vga_y  <= 7'd0;
            bus.colour <= 3'b000;
            bus.plot   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            state_r  <= state_n;
            new_x_r  <= new_x_n;
            old_x_r  <= old_x_n;
            drawn_r  <= drawn_n;
            bus.busy <= scanning_s;
            bus.done <= (state_n == DONE);
            if (scanning_s) begin
                bus.vga_x  <= column_s[7:0];
                bus.vga_y  <= 7'(PADDLE_Y) + 7'(row_off_s);
                bus.colour <= pix_colour_s;
                bus.plot   <= on_screen_s;
            end else begin
                bus.vga_x  <= 8'd0;
                bus.vga_y  <= 7'd0;
                bus.colour <= 3'b000;
                bus.plot   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_paddle_draw.sv
// Self-checking bench for paddle_draw: a queue-based model predicts every
// output cycle, directed scenarios pin counts/extents/latency with literals,
// and a randomized phase exercises go, positions near the edges and resets.
module tb_paddle_draw;

    localparam int HW = 8;
    localparam int PH = 2;
    localparam int PY = 112;
    localparam int N  = (2 * HW + 1) * PH;

    logic clk;
    logic resetn;

    paddle_draw_if bus_if ();

    paddle_draw dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int npass  = 0;
    int ntotal = 0;
    int cyc    = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit plot; int x; int y; int col; bit busy; bit done; bit zero;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   m_drawn;
    int   m_old;

    function automatic exp_t mk(bit p, int x, int y, int c, bit b, bit d, bit z);
        exp_t e;
        e.plot = p; e.x = x; e.y = y; e.col = c; e.busy = b; e.done = d; e.zero = z;
        return e;
    endfunction

    task automatic push_rect(input int centre, input int colour);
        for (int r = 0; r < PH; r++) begin
            for (int c = 0; c < 2 * HW + 1; c++) begin
                int col;
                col = centre - HW + c;
                q.push_back(mk((col >= 0) && (col < 160), col, PY + r, colour, 1'b1, 1'b0, 1'b0));
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!resetn) begin
            q.delete();
            m_drawn = 1'b0;
            m_old   = 0;
            cur     = mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        end else begin
            if (!cur.busy && !cur.done && bus_if.go) begin
                int px;
                px = int'(bus_if.paddle_x);
                if (!(m_drawn && px == m_old)) begin
                    if (m_drawn) push_rect(m_old, 0);
                    push_rect(px, 7);
                end
                q.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0));
                m_old   = px;
                m_drawn = 1'b1;
            end
            if (q.size() > 0) cur = q.pop_front();
            else cur = mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        end
        started = 1'b1;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("plot", int'(bus_if.plot), int'(cur.plot));
            chk("busy", int'(bus_if.busy), int'(cur.busy));
            chk("done", int'(bus_if.done), int'(cur.done));
            if (cur.plot) begin
                chk("vga_x", int'(bus_if.vga_x), cur.x);
                chk("vga_y", int'(bus_if.vga_y), cur.y);
                chk("colour", int'(bus_if.colour), cur.col);
            end
            if (cur.zero) begin
                chk("rst_vga_x", int'(bus_if.vga_x), 0);
                chk("rst_vga_y", int'(bus_if.vga_y), 0);
                chk("rst_colour", int'(bus_if.colour), 0);
            end
        end
    end

    // ---------------- pixel statistics for directed checks ----------------
    int nwhite, nblack, wmin, wmax, bmin, bmax;

    task automatic clear_stats();
        nwhite = 0; nblack = 0; wmin = 999; wmax = -1; bmin = 999; bmax = -1;
    endtask

    always @(negedge clk) begin
        if (started && bus_if.plot) begin
            if (bus_if.colour == 3'b000) begin
                nblack++;
                if (int'(bus_if.vga_x) < bmin) bmin = int'(bus_if.vga_x);
                if (int'(bus_if.vga_x) > bmax) bmax = int'(bus_if.vga_x);
            end else begin
                nwhite++;
                if (int'(bus_if.vga_x) < wmin) wmin = int'(bus_if.vga_x);
                if (int'(bus_if.vga_x) > wmax) wmax = int'(bus_if.vga_x);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int t0;

    task automatic start_go(input int px);
        @(negedge clk);
        clear_stats();
        bus_if.go = 1'b1;
        bus_if.paddle_x = 8'(px);
        @(negedge clk);
        bus_if.go = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int delta);
        int i;
        i = 0;
        while (!bus_if.done && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (bus_if.done) delta = cyc - t0 + 1;
        else delta = -1;
        @(negedge clk);
    endtask

    task automatic run_go(input int px, output int delta);
        start_go(px);
        wait_done(delta);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("reset_plot", int'(bus_if.plot), 0);
        chk("reset_busy", int'(bus_if.busy), 0);
        chk("reset_done", int'(bus_if.done), 0);
        chk("reset_x", int'(bus_if.vga_x), 0);
        resetn = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int d;
        resetn = 1'b0;
        bus_if.go = 1'b0;
        bus_if.paddle_x = 8'd0;
        clear_stats();
        repeat (2) @(negedge clk);
        do_reset();

        // First draw at 70.
        run_go(70, d);
        chk("first_latency", d, 35);
        chk("first_white", nwhite, 34);
        chk("first_black", nblack, 0);
        chk("first_xmin", wmin, 62);
        chk("first_xmax", wmax, 78);

        // Move by one column.
        run_go(71, d);
        chk("move_latency", d, 69);
        chk("move_black", nblack, 34);
        chk("move_bxmin", bmin, 62);
        chk("move_bxmax", bmax, 78);
        chk("move_white", nwhite, 34);
        chk("move_wxmin", wmin, 63);
        chk("move_wxmax", wmax, 79);

        // Unchanged position.
        run_go(71, d);
        chk("same_latency", d, 1);
        chk("same_plots", nwhite + nblack, 0);

        // Left-edge clipping from a fresh reset.
        do_reset();
        run_go(3, d);
        chk("clip_latency", d, 35);
        chk("clip_plots", nwhite, 24);
        chk("clip_xmin", wmin, 0);
        chk("clip_xmax", wmax, 11);

        // go and paddle_x changes mid-DRAW are ignored.
        start_go(20);
        repeat (45) @(negedge clk);
        bus_if.go = 1'b1;
        bus_if.paddle_x = 8'd90;
        repeat (2) @(negedge clk);
        bus_if.go = 1'b0;
        wait_done(d);
        chk("mid_latency", d, 69);
        chk("mid_black", nblack, 24);
        chk("mid_white", nwhite, 34);
        chk("mid_wxmin", wmin, 12);
        chk("mid_wxmax", wmax, 28);
        run_go(40, d);
        chk("latched_bxmin", bmin, 12);
        chk("latched_bxmax", bmax, 28);

        // Reset in the middle of an erase.
        start_go(60);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_plot", int'(bus_if.plot), 0);
        chk("midrst_busy", int'(bus_if.busy), 0);
        resetn = 1'b1;
        run_go(50, d);
        chk("after_rst_latency", d, 35);
        chk("after_rst_black", nblack, 0);
        chk("after_rst_white", nwhite, 34);
        chk("after_rst_xmin", wmin, 42);
        chk("after_rst_xmax", wmax, 58);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus_if.go = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: bus_if.paddle_x = 8'($urandom_range(0, 255));
                1: bus_if.paddle_x = 8'($urandom_range(0, 12));
                2: bus_if.paddle_x = 8'($urandom_range(148, 170));
                default: bus_if.paddle_x = bus_if.paddle_x;
            endcase
            resetn = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        resetn = 1'b1;
        bus_if.go = 1'b0;
        repeat (80) @(negedge clk);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
